// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - frame constants and receiver state encodings shared by the UART blocks
package uart_defs;
    localparam int WORD_SIZE_DEF    = 8;
    localparam int CLKS_PER_BIT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STARTING  = 2'd1,
        RECEIVING = 2'd2
    } rx_state_t;
endpackage

// File: rtl/uart_rx_block_if.sv
// rtl/uart_rx_block_if.sv - host-side byte handshake and status of the UART receiver
interface uart_rx_if #(
    parameter int WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] data_bus;
    logic                 read_not_ready_out;
    logic                 read_not_ready_in;
    logic                 error1;
    logic                 error2;

    modport master (
        output data_bus, read_not_ready_out, error1, error2,
        input  read_not_ready_in
    );

    modport slave (
        input  data_bus, read_not_ready_out, error1, error2,
        output read_not_ready_in
    );
endinterface

// File: rtl/rx_shift_register.sv
// rtl/rx_shift_register.sv - LSB-first deserialiser: new bits enter at the MSB and move right
module rx_shift_register #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 bit_in,
    output logic [WORD_SIZE-1:0] data
);
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            data <= '0;
        end else if (enable) begin
            data <= (data >> 1) | (WORD_SIZE'(bit_in) << (WORD_SIZE - 1));
        end
    end
endmodule

// File: rtl/uart_rx_block.sv
// rtl/uart_rx_block.sv - oversampling UART receiver with ready/ack handoff and overrun/framing flags
module uart_rx_block
    import uart_defs::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    serial_in,
    uart_rx_if.master host
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WORD_SIZE + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_IDX  = BW'(WORD_SIZE);

    rx_state_t            state;
    logic [CW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 sync1;
    logic                 serial_s;
    logic [WORD_SIZE-1:0] shift_data;
    logic                 shift_en;
    logic                 shift_clr;

    assign shift_clr = (state == STARTING) && (sample_cnt == HALF_LAST) && !serial_s;
    assign shift_en  = (state == RECEIVING) && (sample_cnt == BIT_LAST) && (bit_cnt != STOP_IDX);

    rx_shift_register #(.WORD_SIZE(WORD_SIZE)) u_shift (
        .clk    (clk),
        .reset  (reset),
        .clear  (shift_clr),
        .enable (shift_en),
        .bit_in (serial_s),
        .data   (shift_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                   <= IDLE;
            sample_cnt              <= '0;
            bit_cnt                 <= '0;
            sync1                   <= 1'b1;
            serial_s                <= 1'b1;
            host.data_bus           <= '0;
            host.read_not_ready_out <= 1'b0;
            host.error1             <= 1'b0;
            host.error2             <= 1'b0;
        end else begin
            sync1    <= serial_in;
            serial_s <= sync1;
            // A stop-sample load below overrides this, so a coincident ack loses.
            if (host.read_not_ready_in) begin
                host.read_not_ready_out <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!serial_s) begin
                        state      <= STARTING;
                        sample_cnt <= '0;
                    end
                end
                STARTING: begin
                    if (sample_cnt == HALF_LAST) begin
                        sample_cnt <= '0;
                        bit_cnt    <= '0;
                        state      <= serial_s ? IDLE : RECEIVING;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                RECEIVING: begin
                    if (sample_cnt == BIT_LAST) begin
                        sample_cnt <= '0;
                        if (bit_cnt != STOP_IDX) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            host.data_bus           <= shift_data;
                            host.read_not_ready_out <= 1'b1;
                            host.error2             <= ~serial_s;
                            host.error1             <= host.read_not_ready_out && !host.read_not_ready_in;
                            state                   <= IDLE;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
